uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter of the board-level design between NUM_REQ byte sources (e.g. LED status echo, GPIO monitor, RX loopback). It performs round-robin arbitration, captures the winning byte, and sequences the transmitter with a one-cycle start pulse. It then waits for the transmitter's completion before granting again. It sits between the requester logic and the UART TX serializer, which drives the TX pin.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width per requester
GNT_W, max(1,$clog2(NUM_REQ)), width of grant index (derived, localparam)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  byte is last of a frame (used only with ARB_LOCK_EN)
req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
tx_start  out  1  one-cycle start pulse to UART transmitter
tx_data  out  DATA_W  byte to transmit, stable from tx_start until tx_done
tx_done  in  1  one-cycle pulse from transmitter when stop bit completes
grant_id  out  GNT_W  index of requester currently owning TX
busy  out  1  high whenever state != IDLE

Behaviour:
- Single clock. Reset is synchronous and active-high. All outputs are registered.
- Reset: state=IDLE, rr_ptr=0, req_ready=0, tx_start=0, tx_data=0, grant_id=0, busy=0. A reset mid-byte aborts immediately. The transmitter shares rst.
- States:
  - IDLE
  - START
  - WAIT
  - HOLD (HOLD exists only with ARB_LOCK_EN)
- IDLE:
  - If any req_valid bit is set, the winner is the first set bit searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - Latch the winner's req_data into tx_data, its req_last into last_q, and its index into grant_id. Go to START.
  - If no req_valid bit is set, stay in IDLE.
- START:
  - Assert tx_start=1 and req_ready[grant_id]=1 for exactly this cycle. Go to WAIT.
- WAIT:
  - Hold tx_data and grant_id.
  - On tx_done: set rr_ptr=(grant_id+1) mod NUM_REQ and go to IDLE.
- Latency: req_valid sampled in IDLE at cycle k gives tx_start and req_ready at cycle k+1. Minimum gap between consecutive tx_start pulses is tx_done cycle + 2.
- Requester rules:
  - Hold req_valid and req_data stable until req_ready is seen.
  - Drop valid, or present the next byte, on the cycle after req_ready.
  - Deasserting req_valid before grant is legal; the request is simply not seen.
- tx_done is ignored outside WAIT, including in the START cycle.
- Simultaneous requests: strict round-robin. The just-served requester has lowest priority next time. A requester that keeps valid high cannot starve others.
- NUM_REQ=1: rr_ptr stays 0 and grant_id is always 0.
- req_ready never goes high for a non-granted requester. tx_start never goes high outside START.

Optional Feature:
Macro ARB_LOCK_EN (frame lock).
- Defined: in WAIT, on tx_done with last_q=0, go to HOLD instead of IDLE, leaving rr_ptr unchanged.
  - HOLD considers only req_valid[grant_id]. When it is set, latch that requester's data and last into tx_data/last_q, then go to START.
  - Other requesters are ignored while in HOLD.
  - On tx_done with last_q=1, update rr_ptr and return to IDLE.
  - busy stays high in HOLD.
- Not defined: req_last is ignored, and every byte is arbitrated independently as described above.

Test Plan:
- Single requester: reset, then req_valid[2]=1, data 8'hA5 → req_ready[2] and tx_start pulse one cycle later, tx_data=A5, grant_id=2. tx_done after 100 cycles → busy low next cycle.
- All four valid continuously with data 8'h10..8'h13 → tx_data sequence 10,11,12,13,10 on successive tx_start pulses. Exactly one req_ready bit per grant.
- tx_done pulsed during IDLE and during the START cycle → ignored. State remains WAIT until a later tx_done.
- Reset asserted in WAIT → next cycle all outputs 0. A request already pending after reset is granted starting the search at index 0.
- ARB_LOCK_EN: req0 sends 3 bytes with last on the third while req1 is valid throughout → bytes from req0 ×3, then req1. Without the macro → interleaved req0, req1, req0, req1.
- req_valid[1] deasserted before IDLE samples it → no req_ready[1], no tx_start, busy stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional frame lock (define ARB_LOCK_EN) keeps the grant until a byte with req_last set.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  localparam int GNT_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_done,
  output logic [GNT_W-1:0]            grant_id,
  output logic                        busy
);

`ifdef ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
`endif

  state_t              state_q, state_d;
  logic [GNT_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [GNT_W-1:0]    grant_id_q, grant_id_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
`ifdef ARB_LOCK_EN
  logic                last_q, last_d;
`else
  logic                unused_last;
  assign unused_last = ^req_last;
`endif

  logic [DATA_W-1:0]   req_byte [NUM_REQ];
  logic                win_found;
  logic [GNT_W-1:0]    win_idx;
  logic [GNT_W-1:0]    cand;
  logic [GNT_W-1:0]    next_ptr;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GNT_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = GNT_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign next_ptr = GNT_W'((int'(grant_id_q) + 1) % NUM_REQ);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    tx_data_d   = tx_data_q;
    req_ready_d = '0;
    tx_start_d  = 1'b0;
`ifdef ARB_LOCK_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          tx_data_d   = req_byte[win_idx];
          grant_id_d  = win_idx;
          req_ready_d = onehot(win_idx);
          tx_start_d  = 1'b1;
          state_d     = START;
`ifdef ARB_LOCK_EN
          last_d      = req_last[win_idx];
`endif
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
`ifdef ARB_LOCK_EN
          if (!last_q) begin
            state_d = HOLD;
          end else begin
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end
`else
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
`endif
        end
      end
`ifdef ARB_LOCK_EN
      // Mid-frame: only the owning requester may continue.
      HOLD: begin
        if (req_valid[grant_id_q]) begin
          tx_data_d   = req_byte[grant_id_q];
          last_d      = req_last[grant_id_q];
          req_ready_d = onehot(grant_id_q);
          tx_start_d  = 1'b1;
          state_d     = START;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      tx_data_q   <= '0;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ARB_LOCK_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      tx_data_q   <= tx_data_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
`ifdef ARB_LOCK_EN
      last_q      <= last_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table plus hand-written multi-cycle sequences.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_done(tx_done), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        done;
    logic [3:0]  e_ready;
    logic        e_start;
    logic [7:0]  e_data;
    logic [1:0]  e_gnt;
    logic        e_busy;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_start(output bit got);
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (tx_start) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  int         cnt0, cnt1;
  logic [7:0] frame_exp [4];

  task automatic drive_frame();
    req_valid = {2'b00, (cnt1 < 4), (cnt0 < 3)};
    req_data  = {16'h0000, 8'hC0 + 8'(cnt1), 8'hB0 + 8'(cnt0)};
    req_last  = {3'b000, (cnt0 == 2)};
  endtask

  initial begin
    bit   got;
    int   low_cnt;
    //               rst valid  data          done  ready   st  data   g  busy
    vecs[0]  = '{1'b1, 4'h0, 32'h00000000, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'h0, 32'h00000000, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'h4, 32'h00A50000, 1'b0, 4'h4, 1'b1, 8'hA5, 2'd2, 1'b1};
    vecs[3]  = '{1'b0, 4'h0, 32'h00000000, 1'b0, 4'h0, 1'b0, 8'hA5, 2'd2, 1'b1};
    vecs[4]  = '{1'b0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd2, 1'b0};
    vecs[5]  = '{1'b0, 4'hF, 32'h13121110, 1'b0, 4'h8, 1'b1, 8'h13, 2'd3, 1'b1};
    vecs[6]  = '{1'b0, 4'hF, 32'h13121110, 1'b0, 4'h0, 1'b0, 8'h13, 2'd3, 1'b1};
    vecs[7]  = '{1'b0, 4'hF, 32'h13121110, 1'b1, 4'h0, 1'b0, 8'h13, 2'd3, 1'b0};
    vecs[8]  = '{1'b0, 4'hF, 32'h13121110, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 1'b1};
    vecs[9]  = '{1'b0, 4'hF, 32'h13121110, 1'b0, 4'h0, 1'b0, 8'h10, 2'd0, 1'b1};
    vecs[10] = '{1'b0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b0, 8'h10, 2'd0, 1'b0};
    vecs[11] = '{1'b0, 4'h0, 32'h00000000, 1'b0, 4'h0, 1'b0, 8'h10, 2'd0, 1'b0};

    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
    #2;
    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst; req_valid = vecs[i].valid; req_data = vecs[i].data;
      tx_done = vecs[i].done;
      step();
      chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].e_ready);
      chk($sformatf("vec%0d_start", i), tx_start, vecs[i].e_start);
      chk($sformatf("vec%0d_data", i), tx_data, vecs[i].e_data);
      chk($sformatf("vec%0d_gnt", i), grant_id, vecs[i].e_gnt);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
    end

    // Single requester with a long transmission.
    do_reset();
    req_valid = 4'b0100; req_data = 32'h00A50000;
    step();
    chk("single_start", tx_start, 1'b1);
    chk("single_ready", req_ready, 4'b0100);
    chk("single_data", tx_data, 8'hA5);
    chk("single_gnt", grant_id, 2'd2);
    req_valid = '0;
    low_cnt = 0;
    for (int n = 0; n < 99; n++) begin
      step();
      if (!busy || tx_start || req_ready != 4'b0) low_cnt++;
    end
    chk("single_wait_busy", low_cnt, 0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("single_done_busy", busy, 1'b0);

    // All four valid continuously: strict rotation.
    do_reset();
    req_valid = 4'hF; req_data = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      wait_start(got);
      chk($sformatf("rr%0d_got_start", k), got, 1'b1);
      chk($sformatf("rr%0d_data", k), tx_data, 8'h10 + 8'(k % 4));
      chk($sformatf("rr%0d_ready", k), req_ready, 4'b0001 << (k % 4));
      step(); step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end

    // tx_done in IDLE and in the START cycle is ignored.
    do_reset();
    tx_done = 1'b1;
    step();
    chk("idle_done_busy", busy, 1'b0);
    chk("idle_done_start", tx_start, 1'b0);
    tx_done = 1'b0;
    req_valid = 4'b0010; req_data = 32'h00007700;
    step();
    chk("ign_start", tx_start, 1'b1);
    req_valid = '0; tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("ign_after_start_busy", busy, 1'b1);
    step(); step(); step();
    chk("ign_still_wait", busy, 1'b1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("ign_real_done", busy, 1'b0);

    // Reset in WAIT; pending request afterwards searched from index 0.
    req_valid = 4'b1000; req_data = 32'h33000000;
    step();
    chk("rstw_gnt3", grant_id, 2'd3);
    req_valid = '0;
    step();
    chk("rstw_in_wait", busy, 1'b1);
    rst = 1'b1; req_valid = 4'b1010; req_data = 32'h33004400;
    step();
    chk("rstw_ready0", req_ready, 4'b0);
    chk("rstw_start0", tx_start, 1'b0);
    chk("rstw_data0", tx_data, 8'h00);
    chk("rstw_gnt0", grant_id, 2'd0);
    chk("rstw_busy0", busy, 1'b0);
    rst = 1'b0;
    step();
    chk("rstw_new_gnt", grant_id, 2'd1);
    chk("rstw_new_data", tx_data, 8'h44);
    chk("rstw_new_ready", req_ready, 4'b0010);

    // Frame of three bytes from req0 competing with req1.
`ifdef ARB_LOCK_EN
    frame_exp = '{8'hB0, 8'hB1, 8'hB2, 8'hC0};
`else
    frame_exp = '{8'hB0, 8'hC0, 8'hB1, 8'hC1};
`endif
    do_reset();
    cnt0 = 0; cnt1 = 0;
    drive_frame();
    for (int k = 0; k < 4; k++) begin
      wait_start(got);
      chk($sformatf("frame%0d_got_start", k), got, 1'b1);
      chk($sformatf("frame%0d_data", k), tx_data, frame_exp[k]);
      if (req_ready[0]) cnt0++;
      if (req_ready[1]) cnt1++;
      drive_frame();
      step(); step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end

    // Request withdrawn while busy is never seen.
    do_reset();
    req_valid = 4'b0001; req_data = 32'h00000055;
    step();
    chk("wd_start", tx_start, 1'b1);
    req_valid = '0;
    step();
    req_valid = 4'b0010; req_data = 32'h00006600;
    step(); step();
    req_valid = '0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    low_cnt = 0;
    for (int n = 0; n < 3; n++) begin
      step();
      if (busy || tx_start || req_ready != 4'b0) low_cnt++;
    end
    chk("wd_no_grant", low_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
